// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions.
//   result_src_t   : writeback result source select (ALU / load data / PC+4 / immediate)
//   REG_ADDR_WIDTH : architectural register index width
package riscv_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_t;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: purely combinational 4:1 mux on result_src_t.
// Reusable wherever a WB-stage value has to be reconstructed (e.g. forwarding).
// Ports:
//   sel_i    : result source select
//   alu_i    : ALU result
//   mem_i    : load data (already extended)
//   pc4_i    : PC+4 link value
//   imm_i    : extended immediate (LUI)
//   result_o : selected value
module wb_result_mux
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  result_src_t           sel_i,
    input  logic [DATA_WIDTH-1:0] alu_i,
    input  logic [DATA_WIDTH-1:0] mem_i,
    input  logic [DATA_WIDTH-1:0] pc4_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    always_comb begin
        result_o = alu_i;
        unique case (sel_i)
            RES_ALU: result_o = alu_i;
            RES_MEM: result_o = mem_i;
            RES_PC4: result_o = pc4_i;
            RES_IMM: result_o = imm_i;
            default: result_o = alu_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback result select.
// Captures MEM-stage data and control each cycle (flush > stall > load), selects the
// writeback value from registered fields only, and qualifies the register-file write.
// Optional: define MEM_WB_INSTRET_EN to build the 64-bit retired-instruction counter;
// without it InstretW_o is tied to 0.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   StallW_i, FlushW_i            : hazard-unit hold / bubble requests
//   ValidM_i .. ResultSrcM_i      : MEM-stage slot contents
//   ResultW_o                     : writeback value, also the WB forwarding source
//   RdW_o                         : writeback destination (x0 passed through)
//   RegWriteW_o                   : write enable, suppressed for bubbles and x0
//   ValidW_o                      : WB slot holds a real instruction
//   InstretW_o                    : retired-instruction count
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      StallW_i,
    input  logic                      FlushW_i,
    input  logic                      ValidM_i,
    input  logic [DATA_WIDTH-1:0]     ALUResultM_i,
    input  logic [DATA_WIDTH-1:0]     RDM_i,
    input  logic [DATA_WIDTH-1:0]     PCPlus4M_i,
    input  logic [DATA_WIDTH-1:0]     ImmExtM_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
    input  logic                      RegWriteM_i,
    input  logic [1:0]                ResultSrcM_i,
    output logic [DATA_WIDTH-1:0]     ResultW_o,
    output logic [REG_ADDR_WIDTH-1:0] RdW_o,
    output logic                      RegWriteW_o,
    output logic                      ValidW_o,
    output logic [63:0]               InstretW_o
);

    logic                      valid_q,    valid_d;
    logic                      regwrite_q, regwrite_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,       rd_d;
    result_src_t               src_q,      src_d;
    logic [DATA_WIDTH-1:0]     alu_q,      alu_d;
    logic [DATA_WIDTH-1:0]     mem_q,      mem_d;
    logic [DATA_WIDTH-1:0]     pc4_q,      pc4_d;
    logic [DATA_WIDTH-1:0]     imm_q,      imm_d;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        src_d      = src_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        pc4_d      = pc4_q;
        imm_d      = imm_q;
        if (FlushW_i) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            rd_d       = '0;
            src_d      = RES_ALU;
            alu_d      = '0;
            mem_d      = '0;
            pc4_d      = '0;
            imm_d      = '0;
        end else if (!StallW_i) begin
            valid_d    = ValidM_i;
            regwrite_d = RegWriteM_i;
            rd_d       = RdM_i;
            src_d      = result_src_t'(ResultSrcM_i);
            alu_d      = ALUResultM_i;
            mem_d      = RDM_i;
            pc4_d      = PCPlus4M_i;
            imm_d      = ImmExtM_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            src_q      <= RES_ALU;
            alu_q      <= '0;
            mem_q      <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            src_q      <= src_d;
            alu_q      <= alu_d;
            mem_q      <= mem_d;
            pc4_q      <= pc4_d;
            imm_q      <= imm_d;
        end
    end

    wb_result_mux #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_result_mux (
        .sel_i    (src_q),
        .alu_i    (alu_q),
        .mem_i    (mem_q),
        .pc4_i    (pc4_q),
        .imm_i    (imm_q),
        .result_o (ResultW_o)
    );

    assign RdW_o       = rd_q;
    assign ValidW_o    = valid_q;
    assign RegWriteW_o = regwrite_q & valid_q & (rd_q != '0);

`ifdef MEM_WB_INSTRET_EN
    logic [63:0] instret_q;

    // The WB occupant leaves whenever the register is not held; a flush evicts it
    // even under stall, so it still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (valid_q && (FlushW_i || !StallW_i)) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign InstretW_o = instret_q;
`else
    assign InstretW_o = '0;
`endif

endmodule
